writeback: RTL and testbench

// - LC3 writeback stage plus architectural register file; the responder to the execute stage's

---
 rtl/writeback_if.sv | 31 +++
 rtl/writeback.sv | 89 ++++++++
 tb/tb_writeback.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/writeback_if.sv
// Register-read / commit bundle between the execute-side pipeline and the writeback stage.
// The master (execute/memaccess side) drives read indices and commit results; the slave
// (writeback) returns the read data and the condition codes.
interface writeback_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8
);
    localparam int unsigned AW = $clog2(NREGS);

    logic              enable_writeback;
    logic [1:0]        W_control;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] memout;
    logic [DATA_W-1:0] pcout;
    logic [AW-1:0]     dr;
    logic [AW-1:0]     sr1;
    logic [AW-1:0]     sr2;
    logic [DATA_W-1:0] VSR1;
    logic [DATA_W-1:0] VSR2;
    logic [2:0]        psr;

    modport master (
        output enable_writeback, W_control, aluout, memout, pcout, dr, sr1, sr2,
        input  VSR1, VSR2, psr
    );

    modport slave (
        input  enable_writeback, W_control, aluout, memout, pcout, dr, sr1, sr2,
        output VSR1, VSR2, psr
    );
endinterface

// File: rtl/writeback.sv
// LC3 writeback stage and architectural register file.
// Selects the committed result (ALU, memory or PC), writes it to R[dr] and updates the
// {N,Z,P} condition codes. Two combinational read ports serve the execute stage.
// Optional feature: define WB_BYPASS_EN to forward the committing value to a read port
// whose index matches dr in the same cycle; otherwise reads always see the stored array
// and decode must stall one cycle on a read-after-write.
module writeback #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8
) (
    input logic       clk,
    input logic       rst,
    writeback_if.slave wb
);
    localparam int unsigned AW = $clog2(NREGS);

    localparam logic [1:0] SelAlu  = 2'd0;
    localparam logic [1:0] SelMem  = 2'd1;
    localparam logic [1:0] SelPc   = 2'd2;
    localparam logic [1:0] SelNone = 2'd3;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [2:0]        psr_q;
    logic [2:0]        psr_d;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // Result select; the no-write code yields zero so wdata never floats to stale inputs.
    always_comb begin
        wdata = '0;
        unique case (wb.W_control)
            SelAlu:  wdata = wb.aluout;
            SelMem:  wdata = wb.memout;
            SelPc:   wdata = wb.pcout;
            SelNone: wdata = '0;
            default: wdata = '0;
        endcase
    end

    // Commit qualifier and next condition codes; exactly one of N/Z/P is set on a write.
    always_comb begin
        we    = wb.enable_writeback & (wb.W_control != SelNone) & ~rst;
        psr_d = psr_q;
        if (we) begin
            psr_d = {wdata[DATA_W-1], (wdata == '0), ~wdata[DATA_W-1] & (wdata != '0)};
        end
    end

    // Register file and PSR state; reset has priority over a pending commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            psr_q <= 3'b000;
        end else begin
            if (we) begin
                regs_q[wb.dr] <= wdata;
            end
            psr_q <= psr_d;
        end
    end

    // Combinational read ports, with optional write-through forwarding.
    always_comb begin
        rd1 = regs_q[wb.sr1];
        rd2 = regs_q[wb.sr2];
`ifdef WB_BYPASS_EN
        if (we && (wb.sr1 == wb.dr)) begin
            rd1 = wdata;
        end
        if (we && (wb.sr2 == wb.dr)) begin
            rd2 = wdata;
        end
`else
        rd1 = regs_q[wb.sr1];
        rd2 = regs_q[wb.sr2];
`endif
    end

    assign wb.VSR1 = rd1;
    assign wb.VSR2 = rd2;
    assign wb.psr  = psr_q;

    logic [AW-1:0] unused_aw;
    assign unused_aw = '0;
endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: a reference model of the register file and PSR
// predicts each commit; expectations are queued when stimulus is driven and compared
// after the commit edge.
module tb_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;

    writeback_if bus ();

    writeback dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] val;
        logic [2:0]  psr;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_regs [8];
    logic [2:0]  m_psr;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] calc_psr(input logic [15:0] v);
        return {v[15], (v == 16'h0), ~v[15] & (v != 16'h0)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_psr = 3'b000;
    endtask

    // Drive one commit, predict it, then compare after the edge via the scoreboard.
    task automatic commit(input logic en, input logic [1:0] ctl, input logic [15:0] a,
                          input logic [15:0] m, input logic [15:0] p, input logic [2:0] d,
                          input logic [2:0] s2);
        exp_t        e;
        logic [15:0] wd;
        bus.enable_writeback = en;
        bus.W_control        = ctl;
        bus.aluout           = a;
        bus.memout           = m;
        bus.pcout            = p;
        bus.dr               = d;
        wd = (ctl == 2'd0) ? a : (ctl == 2'd1) ? m : (ctl == 2'd2) ? p : 16'h0;
        if (en && ctl != 2'd3) begin
            m_regs[d] = wd;
            m_psr     = calc_psr(wd);
        end
        e.idx = d;
        e.val = m_regs[d];
        e.psr = m_psr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.enable_writeback = 1'b0;
        bus.W_control        = 2'd3;
        e = sb_q.pop_front();
        bus.sr1 = e.idx;
        bus.sr2 = s2;
        #1;
        check("commit_vsr1", bus.VSR1, e.val);
        check("commit_psr", {13'h0, bus.psr}, {13'h0, e.psr});
        check("commit_vsr2", bus.VSR2, m_regs[s2]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable_writeback = 1'b0;
        bus.W_control        = 2'd3;
        bus.aluout           = 16'h0;
        bus.memout           = 16'h0;
        bus.pcout            = 16'h0;
        bus.dr               = 3'd0;
        bus.sr1              = 3'd0;
        bus.sr2              = 3'd0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_psr", {13'h0, bus.psr}, 16'h0);
        for (int i = 0; i < 8; i++) begin
            bus.sr1 = 3'(i);
            #1 check("reset_reg", bus.VSR1, 16'h0);
        end

        // Select paths and PSR codes
        commit(1'b1, 2'd0, 16'h8001, 16'h0, 16'h0, 3'd2, 3'd0);
        check("alu_psr_n", {13'h0, bus.psr}, 16'h0004);
        commit(1'b1, 2'd1, 16'h1111, 16'h0000, 16'h2222, 3'd5, 3'd2);
        check("mem_psr_z", {13'h0, bus.psr}, 16'h0002);
        commit(1'b1, 2'd2, 16'h1111, 16'h4444, 16'h3005, 3'd7, 3'd5);
        check("pc_psr_p", {13'h0, bus.psr}, 16'h0001);

        // No-write cases
        commit(1'b1, 2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd2, 3'd7);
        check("nowrite_ctl3", bus.VSR1, 16'h8001);
        commit(1'b0, 2'd0, 16'hFFFF, 16'h0, 16'h0, 3'd2, 3'd7);
        check("nowrite_en0", bus.VSR1, 16'h8001);
        check("nowrite_psr", {13'h0, bus.psr}, 16'h0001);

        // Dual read of the same register
        bus.sr1 = 3'd7;
        bus.sr2 = 3'd7;
        #1;
        check("dual_vsr1", bus.VSR1, 16'h3005);
        check("dual_vsr2", bus.VSR2, 16'h3005);

        // R0 is an ordinary register
        commit(1'b1, 2'd0, 16'h7FFF, 16'h0, 16'h0, 3'd0, 3'd0);
        check("r0_normal", bus.VSR2, 16'h7FFF);

        // Same-cycle read-after-write
        commit(1'b1, 2'd0, 16'h0011, 16'h0, 16'h0, 3'd4, 3'd4);
        bus.enable_writeback = 1'b1;
        bus.W_control        = 2'd0;
        bus.aluout           = 16'h0022;
        bus.dr               = 3'd4;
        bus.sr1              = 3'd4;
        bus.sr2              = 3'd5;
        #1;
`ifdef WB_BYPASS_EN
        check("raw_vsr1", bus.VSR1, 16'h0022);
`else
        check("raw_vsr1", bus.VSR1, 16'h0011);
`endif
        check("raw_vsr2_other", bus.VSR2, 16'h0000);
        m_regs[4] = 16'h0022;
        m_psr     = calc_psr(16'h0022);
        @(posedge clk);
        #1 bus.enable_writeback = 1'b0;
        #1 check("raw_after", bus.VSR1, 16'h0022);

        // Randomised commits
        for (int n = 0; n < 60; n++) begin
            commit(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                   16'($urandom), 16'($urandom_range(0, 1) ? 0 : $urandom), 16'($urandom),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        // Reset mid-stream discards the pending commit
        commit(1'b1, 2'd0, 16'h1234, 16'h0, 16'h0, 3'd3, 3'd3);
        bus.enable_writeback = 1'b1;
        bus.W_control        = 2'd0;
        bus.aluout           = 16'h5555;
        bus.dr               = 3'd3;
        rst                  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.enable_writeback = 1'b0;
        model_reset();
        bus.sr1 = 3'd3;
        bus.sr2 = 3'd2;
        #1;
        check("midrst_r3", bus.VSR1, 16'h0);
        check("midrst_r2", bus.VSR2, 16'h0);
        check("midrst_psr", {13'h0, bus.psr}, 16'h0);
        commit(1'b1, 2'd1, 16'h0, 16'hA5A5, 16'h0, 3'd6, 3'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
